if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the architectural PC, presents it to the next-PC logic and to instruction memory, and loads the next PC from the NPC block's output every advancing cycle. It also owns the IF/ID pipeline register, which feeds PCID and InstructionID back to the NPC block and to decode. It supports variable-latency instruction memory, hazard stalls and an ID flush.

---
 rtl/if_fetch_stage_pkg.sv | 25 ++
 rtl/if_fetch_stage_if.sv | 27 ++
 rtl/if_fetch_stage_if_id_reg.sv | 35 +++
 rtl/if_fetch_stage.sv | 112 +++++++++++
 tb/tb_if_fetch_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_stage_pkg
// Brief   : Shared constants and types for the fetch stage and IF/ID register.
// Revision: 1.0
// ============================================================================
package if_fetch_stage_pkg;

  localparam logic [31:0] c_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Pipeline bundle, also reused by the ID/EX register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_stage_if
// Brief   : Instruction-memory request/acknowledge bus.
// Revision: 1.0
// ============================================================================
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register with load, hold and flush-to-bubble.
// Revision: 1.0
// ============================================================================
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  input  wire logic   load,
  input  wire logic   hold,
  input  wire logic   flush,
  input  wire if_id_t d,
  output if_id_t      q
);

  if_id_t w_bubble;
  assign w_bubble = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= w_bubble;
    end else if (flush) begin
      q <= w_bubble;
    end else if (load && !hold) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_stage
// Brief   : MIPS fetch stage: PC, variable-latency fetch FSM, IF/ID register.
// Revision: 1.0
// ============================================================================
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic [31:0] npc,
  input  wire logic        stall,
  input  wire logic        flush,
  if_fetch_stage_if.master imem,
  output logic [31:0]      pc,
  output logic [31:0]      pc_id,
  output logic [31:0]      pc8_id,
  output logic [31:0]      instr_id,
  output logic             valid_id,
  output logic             if_busy,
  output logic             addr_err
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_buf;
  logic         w_advance;
  logic         w_load;
  logic         w_pc_en;
  logic         w_buf_en;
  if_id_t       w_if_id_d;
  if_id_t       w_if_id_q;

  assign if_busy   = (r_state == FETCH) && !imem.imem_ack;
  assign w_advance = !stall && !if_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush wins; a late ack in the flush cycle is simply not captured.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pc_en     = 1'b0;
    w_buf_en    = 1'b0;
    if (flush) begin
      w_state_nxt = FETCH;
      w_pc_en     = 1'b1;
    end else if (w_advance) begin
      w_state_nxt = FETCH;
      w_load      = 1'b1;
      w_pc_en     = 1'b1;
    end else if ((r_state == FETCH) && imem.imem_ack) begin
      w_state_nxt = HOLD;
      w_buf_en    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc  <= RESET_PC;
      r_buf <= NOP_INSTR;
    end else begin
      if (w_pc_en) begin
        r_pc <= npc;
      end
      if (flush) begin
        r_buf <= NOP_INSTR;
      end else if (w_buf_en) begin
        r_buf <= imem.imem_rdata;
      end
    end
  end

  assign w_if_id_d.pc    = r_pc;
  assign w_if_id_d.instr = (r_state == HOLD) ? r_buf : imem.imem_rdata;
  assign w_if_id_d.valid = 1'b1;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .hold    (stall),
    .flush   (flush),
    .d       (w_if_id_d),
    .q       (w_if_id_q)
  );

  assign imem.imem_req  = reset_n && (r_state == FETCH);
  assign imem.imem_addr = r_pc;

  assign pc       = r_pc;
  assign pc_id    = w_if_id_q.pc;
  assign pc8_id   = w_if_id_q.pc + 32'd8;
  assign instr_id = w_if_id_q.instr;
  assign valid_id = w_if_id_q.valid;
  assign addr_err = (r_pc[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_stage
// Brief   : Directed and randomized checks of if_fetch_stage against a model.
// Revision: 1.0
// ============================================================================
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        ack_en;
  logic [31:0] npc;
  logic [31:0] salt;
  logic [31:0] pc, pc_id, pc8_id, instr_id;
  logic        valid_id, if_busy, addr_err;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural view only.
  logic [31:0] m_pc, m_pc_id, m_instr;
  logic        m_valid;
  logic [31:0] m_held[$];

  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  assign bus.imem_ack   = bus.imem_req & ack_en;
  assign bus.imem_rdata = {bus.imem_addr[15:0], ~bus.imem_addr[15:0]} ^ salt;

  if_fetch_stage dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .npc      (npc),
    .stall    (stall),
    .flush    (flush),
    .imem     (bus),
    .pc       (pc),
    .pc_id    (pc_id),
    .pc8_id   (pc8_id),
    .instr_id (instr_id),
    .valid_id (valid_id),
    .if_busy  (if_busy),
    .addr_err (addr_err)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_3000;
    m_pc_id = 32'h0;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_held.delete();
  endtask

  task automatic check_all();
    logic req_exp;
    req_exp = (m_held.size() == 0);
    check("imem_req",  {31'b0, bus.imem_req}, {31'b0, req_exp});
    check("imem_addr", bus.imem_addr, m_pc);
    check("pc",        pc, m_pc);
    check("if_busy",   {31'b0, if_busy}, {31'b0, req_exp && !ack_en});
    check("addr_err",  {31'b0, addr_err}, {31'b0, m_pc[1:0] != 2'b00});
    check("pc_id",     pc_id, m_pc_id);
    check("pc8_id",    pc8_id, m_pc_id + 32'd8);
    check("instr_id",  instr_id, m_instr);
    check("valid_id",  {31'b0, valid_id}, {31'b0, m_valid});
  endtask

  // One cycle: drive, check current outputs, advance the model, clock.
  task automatic step(input logic s, input logic f, input logic a, input logic [31:0] n);
    stall  = s;
    flush  = f;
    ack_en = a;
    npc    = n;
    #1;
    check_all();
    if (f) begin
      m_pc_id = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_held.delete();
      m_pc = n;
    end else if (m_held.size() != 0) begin
      if (!s) begin
        m_pc_id = m_pc; m_instr = m_held.pop_front(); m_valid = 1'b1;
        m_pc = n;
      end
    end else if (a) begin
      if (!s) begin
        m_pc_id = m_pc; m_instr = word_at(m_pc); m_valid = 1'b1;
        m_pc = n;
      end else begin
        m_held.push_back(word_at(m_pc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    salt    = $urandom;
    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    ack_en  = 1'b1;
    npc     = 32'h0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req",   {31'b0, bus.imem_req}, 32'h0);
    check("rst_pc",    pc, 32'h0000_3000);
    check("rst_valid", {31'b0, valid_id}, 32'h0);
    check("rst_instr", instr_id, 32'h0);
    reset_n = 1'b1;

    // Zero-wait stream.
    step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
    // Three-cycle memory wait at 0x3004.
    repeat (3) step(1'b0, 1'b0, 1'b0, m_pc + 32'd4);
    step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
    // Stall while ack arrives at 0x3008.
    step(1'b1, 1'b0, 1'b1, m_pc + 32'd4);
    step(1'b1, 1'b0, 1'b1, m_pc + 32'd4);
    step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
    // Branch in ID resolving to 0x3020; delay slot at 0x300C still enters ID.
    step(1'b0, 1'b0, 1'b1, 32'h0000_3020);
    check("branch_target", pc, 32'h0000_3020);
    check("delay_slot_pc", pc_id, 32'h0000_300C);
    // Flush while holding.
    step(1'b1, 1'b0, 1'b1, m_pc + 32'd4);
    step(1'b1, 1'b1, 1'b1, 32'h0000_4180);
    check("flush_pc", pc, 32'h0000_4180);
    check("flush_valid", {31'b0, valid_id}, 32'h0);
    // pc8 wrap-around.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0002);
    check("pc8_wrap", pc8_id, 32'h0000_0004);
    // Misaligned pc, then reset asserted mid-wait.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pc",    pc, 32'h0000_3000);
    check("mid_rst_valid", {31'b0, valid_id}, 32'h0);
    check("mid_rst_req",   {31'b0, bus.imem_req}, 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_req2",  {31'b0, bus.imem_req}, 32'h0);
    reset_n = 1'b1;
    model_reset();

    repeat (400) begin
      logic        s, f, a;
      logic [31:0] n;
      int          r;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 11) == 0);
      a = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)      n = m_pc + 32'd4;
      else if (r < 9) n = $urandom & 32'hFFFF_FFFC;
      else            n = $urandom;
      step(s, f, a, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
